hyperbus_responder: RTL

- Synthesizable HyperBus memory responder: the device end of the link driven by the hyperbus controller PHY.
- Used as the on-chip bus partner in controller regression benches and in FPGA loopback builds.
- Operates on the DDR-demuxed, one-word-per-cycle view of the bus: dq [15:8] is the rising-edge byte, [7:0] the falling-edge byte.
- Decodes the 48-bit command/address (CA), applies initial latency, serves linear and wrapped read/write bursts from an internal word array, and serves a small register space.

---
 rtl/hyperbus_responder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder on the DDR-demuxed word view of the bus.
// Decodes the 48-bit CA, applies initial latency and serves memory/register bursts.
module hyperbus_responder #(
  parameter int unsigned MEM_WORDS        = 1024,
  parameter int unsigned LATENCY          = 6,
  parameter bit          FIXED_DOUBLE_LAT = 1'b1,
  parameter int unsigned WRAP_WORDS       = 16,
  parameter logic [15:0] ID0_VAL          = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o,
  output logic [2:0]  state_o
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam int unsigned WW       = $clog2(WRAP_WORDS);
  localparam int unsigned LAT_L    = LATENCY * (FIXED_DOUBLE_LAT ? 2 : 1);
  localparam logic [3:0]  LAT_LOAD = 4'(LAT_L - 1);
  localparam logic [31:0] CR0_ADDR = 32'h0000_0800;
  localparam logic [31:0] CR1_ADDR = 32'h0000_0801;
  localparam logic [WW-1:0] WRAP_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CA     = 3'd1,
    S_LAT    = 3'd2,
    S_WR     = 3'd3,
    S_RD     = 3'd4,
    S_REGWR  = 3'd5,
    S_WAITCS = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        ca_phase_q, ca_phase_d;
  logic [31:0] ca_hi_q, ca_hi_d;       // CA[47:16]
  logic [31:0] addr_q, addr_d;
  logic [3:0]  lat_q, lat_d;
  logic [15:0] cr0_q, cr0_d;
  logic [15:0] cr1_q, cr1_d;
  logic [15:0] dq_q, dq_d;
  logic        dq_oe_q, dq_oe_d;
  logic [1:0]  rwds_q, rwds_d;
  logic        rwds_oe_q, rwds_oe_d;

  logic        is_read;
  logic        is_reg;
  logic        is_linear;
  logic        mem_we;
  logic [31:0] addr_next;
  logic [15:0] reg_rdata;
  logic [15:0] rd_data;
  logic [AW-1:0] mem_idx;
  logic [1:0][7:0] rd_bytes;

  assign is_read   = ca_hi_q[31];
  assign is_reg    = ca_hi_q[30];
  assign is_linear = ca_hi_q[29];
  assign mem_idx   = addr_q[AW-1:0];

  // Register reads always advance linearly; the full-width address keeps
  // 0x800/0x801 distinct from memory aliases.
  always_comb begin
    if (is_linear || is_reg) begin
      addr_next = addr_q + 32'd1;
    end else begin
      addr_next = {addr_q[31:WW], addr_q[WW-1:0] + WRAP_ONE};
    end
  end

  always_comb begin
    unique case (addr_q)
      32'd0:    reg_rdata = ID0_VAL;
      32'd1:    reg_rdata = 16'h0000;
      CR0_ADDR: reg_rdata = cr0_q;
      CR1_ADDR: reg_rdata = cr1_q;
      default:  reg_rdata = 16'h0000;
    endcase
  end

  assign rd_data = is_reg ? reg_rdata : {rd_bytes[1], rd_bytes[0]};

  // One byte-wide bank per rwds lane so masked writes need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] bank_mem [MEM_WORDS];
      always_ff @(posedge clk_i) begin
        if (mem_we && !rwds_i[gi]) begin
          bank_mem[mem_idx] <= dq_i[gi*8 +: 8];
        end
      end
      assign rd_bytes[gi] = bank_mem[mem_idx];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    ca_phase_d = ca_phase_q;
    ca_hi_d    = ca_hi_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    cr0_d      = cr0_q;
    cr1_d      = cr1_q;
    dq_d       = dq_q;
    dq_oe_d    = dq_oe_q;
    rwds_d     = rwds_q;
    rwds_oe_d  = rwds_oe_q;
    mem_we     = 1'b0;

    if (cs_ni) begin
      state_d   = S_IDLE;
      dq_d      = 16'h0000;
      dq_oe_d   = 1'b0;
      rwds_d    = 2'b00;
      rwds_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ca_hi_d[31:16] = dq_i;
          ca_phase_d     = 1'b0;
          state_d        = S_CA;
          rwds_oe_d      = 1'b1;
          rwds_d         = {2{FIXED_DOUBLE_LAT}};
        end
        S_CA: begin
          if (!ca_phase_q) begin
            ca_hi_d[15:0] = dq_i;
            ca_phase_d    = 1'b1;
          end else begin
            rwds_oe_d = 1'b0;
            rwds_d    = 2'b00;
            addr_d    = {ca_hi_q[28:0], dq_i[2:0]};
            if (!is_read && is_reg) begin
              state_d = S_REGWR;
            end else begin
              state_d = S_LAT;
              lat_d   = LAT_LOAD;
            end
          end
        end
        S_LAT: begin
          // The zero-count edge already carries the first data beat.
          if (lat_q != 4'd0) begin
            lat_d = lat_q - 4'd1;
          end else if (is_read) begin
            dq_d      = rd_data;
            dq_oe_d   = 1'b1;
            rwds_d    = 2'b10;
            rwds_oe_d = 1'b1;
            addr_d    = addr_next;
            state_d   = S_RD;
          end else begin
            mem_we  = 1'b1;
            addr_d  = addr_next;
            state_d = S_WR;
          end
        end
        S_WR: begin
          mem_we = 1'b1;
          addr_d = addr_next;
        end
        S_RD: begin
          dq_d      = rd_data;
          dq_oe_d   = 1'b1;
          rwds_d    = 2'b10;
          rwds_oe_d = 1'b1;
          addr_d    = addr_next;
        end
        S_REGWR: begin
          if (addr_q == CR0_ADDR) begin
            cr0_d = dq_i;
          end else if (addr_q == CR1_ADDR) begin
            cr1_d = dq_i;
          end
          state_d = S_WAITCS;
        end
        S_WAITCS: begin
          state_d = S_WAITCS;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ca_phase_q <= 1'b0;
      ca_hi_q    <= 32'h0;
      addr_q     <= 32'h0;
      lat_q      <= 4'h0;
      cr0_q      <= 16'h8F1F;
      cr1_q      <= 16'h0002;
      dq_q       <= 16'h0000;
      dq_oe_q    <= 1'b0;
      rwds_q     <= 2'b00;
      rwds_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ca_phase_q <= ca_phase_d;
      ca_hi_q    <= ca_hi_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      cr0_q      <= cr0_d;
      cr1_q      <= cr1_d;
      dq_q       <= dq_d;
      dq_oe_q    <= dq_oe_d;
      rwds_q     <= rwds_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  assign dq_o      = dq_q;
  assign dq_oe_o   = dq_oe_q;
  assign rwds_o    = rwds_q;
  assign rwds_oe_o = rwds_oe_q;
  assign state_o   = state_q;

endmodule
